// File: rtl/seven_seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : seven_seg_scan_ctrl
// Description : Time-multiplexed six-digit seven-segment scan controller.
//               Steps mux_sel through digits 0..5, decodes the returned BCD
//               digit into active-low segments, and drives one active-low
//               anode per slot. Each slot opens with a blanking gap.
//               Optional macro SEVEN_SEG_HEX_EN enables decoding of hex
//               digits A..F; without it, codes 10..15 are shown blank.
// Revision    : 1.0 - initial release
// ============================================================================
module seven_seg_scan_ctrl #(
  parameter int CLK_DIV      = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [3:0] digit_in,
  input  logic [5:0] dp_mask,
  output logic [2:0] mux_sel,
  output logic [5:0] an_n,
  output logic [6:0] seg_n,
  output logic       dp_n,
  output logic       frame_tick
);

  localparam int              CNT_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] C_TC    = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] C_BLANK = CNT_W'(BLANK_CYCLES);
  localparam logic [2:0]       C_LAST  = 3'd5;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       mux_sel_q, mux_sel_d;
  logic [5:0]       an_n_q, an_n_d;
  logic [6:0]       seg_n_q, seg_n_d;
  logic             dp_n_q, dp_n_d;
  logic             tick_q, tick_d;
  logic             w_terminal;
  logic [7:0]       w_dp_ext;

  // Prescaler / digit sequencing; anode and tick computed from next state so
  // the registered outputs line up with the registered counter and select.
  always_comb begin
    w_terminal = en && (cnt_q == C_TC);
    cnt_d      = cnt_q;
    mux_sel_d  = mux_sel_q;
    an_n_d     = 6'h3F;
    tick_d     = 1'b0;
    if (!en) begin
      cnt_d = '0;
    end else if (w_terminal) begin
      cnt_d     = '0;
      mux_sel_d = (mux_sel_q == C_LAST) ? 3'd0 : mux_sel_q + 3'd1;
      tick_d    = (mux_sel_q == C_LAST);
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
    if (en && (cnt_d >= C_BLANK)) begin
      an_n_d = ~(6'd1 << mux_sel_d);
    end
  end

  // Segment decode of the digit currently returned by the external mux.
  always_comb begin
    seg_n_d = 7'h7F;
    case (digit_in)
      4'd0:    seg_n_d = 7'b1000000;
      4'd1:    seg_n_d = 7'b1111001;
      4'd2:    seg_n_d = 7'b0100100;
      4'd3:    seg_n_d = 7'b0110000;
      4'd4:    seg_n_d = 7'b0011001;
      4'd5:    seg_n_d = 7'b0010010;
      4'd6:    seg_n_d = 7'b0000010;
      4'd7:    seg_n_d = 7'b1111000;
      4'd8:    seg_n_d = 7'b0000000;
      4'd9:    seg_n_d = 7'b0010000;
`ifdef SEVEN_SEG_HEX_EN
      4'd10:   seg_n_d = 7'b0001000;
      4'd11:   seg_n_d = 7'b0000011;
      4'd12:   seg_n_d = 7'b1000110;
      4'd13:   seg_n_d = 7'b0100001;
      4'd14:   seg_n_d = 7'b0000110;
      4'd15:   seg_n_d = 7'b0001110;
`else
      default: seg_n_d = 7'h7F;
`endif
    endcase
  end

  // Decimal point follows the currently selected digit; padded so that the
  // 3-bit select always indexes inside the vector.
  always_comb begin
    w_dp_ext = {2'b00, dp_mask};
    dp_n_d   = ~w_dp_ext[mux_sel_q];
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      mux_sel_q <= 3'd0;
      an_n_q    <= 6'h3F;
      seg_n_q   <= 7'h7F;
      dp_n_q    <= 1'b1;
      tick_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      mux_sel_q <= mux_sel_d;
      an_n_q    <= an_n_d;
      seg_n_q   <= seg_n_d;
      dp_n_q    <= dp_n_d;
      tick_q    <= tick_d;
    end
  end

  assign mux_sel    = mux_sel_q;
  assign an_n       = an_n_q;
  assign seg_n      = seg_n_q;
  assign dp_n       = dp_n_q;
  assign frame_tick = tick_q;

endmodule
`default_nettype wire

// File: doc/seven_seg_scan_ctrl.md
# seven_seg_scan_ctrl

Time-multiplexed driver for the six-digit seven-segment display. It generates `mux_sel` for `seven_seg_mux`, takes back the selected BCD digit, and decodes it into active-low segment lines. It drives one active-low anode per digit, with a blanking gap at every digit change to prevent ghosting. It sits between `seven_seg_mux` and the board display pins.

## Interface
Parameters:
- `CLK_DIV`, default 50000: clock cycles per digit slot. Legal when `CLK_DIV` ≥ `BLANK_CYCLES`+2.
- `BLANK_CYCLES`, default 16: cycles at the start of each slot with all anodes off. Legal when ≥ 1.

Ports:
- `clk` in 1: single clock. All state is clocked on the rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `en` in 1: scan enable.
- `digit_in` in 4: digit value from `seven_seg_mux` `data_out`. It is combinational from `mux_sel`.
- `dp_mask` in 6: decimal point request per digit; bit k belongs to digit k.
- `mux_sel` out 3: digit select to `seven_seg_mux`. Range 0..5.
- `an_n` out 6: active-low anode enables; bit k drives digit k.
- `seg_n` out 7: active-low segments, ordered {g,f,e,d,c,b,a}.
- `dp_n` out 1: active-low decimal point.
- `frame_tick` out 1: one-cycle pulse at the start of each full 6-digit frame.

## Operation
- Prescaler `cnt` counts 0..`CLK_DIV`-1 while `en`=1.
  - At terminal count, on the next edge: `cnt`→0 and `mux_sel`→`mux_sel`+1.
  - `mux_sel` wraps 5→0. Values 6 and 7 never occur.
- Anodes:
  - `an_n` is all-ones while `cnt` < `BLANK_CYCLES`.
  - Otherwise `an_n` = ~(1<<`mux_sel`), i.e. exactly one bit low.
  - `an_n` is registered and aligned with `cnt`/`mux_sel`.
- Segments:
  - `seg_n` is registered every cycle from decode(`digit_in`).
  - Decode table:
    - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
    - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - Codes 10..15: see Configuration.
- Decimal point: `dp_n` is registered as ~`dp_mask`[`mux_sel`].
- Frame tick: `frame_tick`=1 for exactly the one cycle in which `cnt`=0 and `mux_sel`=0, immediately after a 5→0 wrap.
- `en`=0:
  - `cnt` is held at 0 and `mux_sel` holds its value.
  - `an_n`=6'h3F and `frame_tick`=0.
  - `seg_n` and `dp_n` keep updating.
- Re-enable: the slot restarts at `cnt`=0, so the blank period always precedes anode drive.
- `en` drop at the terminal-count cycle: no advance occurs.

## Timing
- Reset values (asynchronous, apply immediately, also mid-frame):
  - `mux_sel`=0, `cnt`=0
  - `an_n`=6'h3F, `seg_n`=7'h7F, `dp_n`=1, `frame_tick`=0
- After `rst_n` release with `en`=1:
  - Slot 0 begins.
  - First anode low at cycle `BLANK_CYCLES`.
  - First `mux_sel` change after `CLK_DIV` cycles.
- Segment latency: 1 cycle from `mux_sel` change to matching `seg_n`/`dp_n`. This lag is always hidden inside the blank window, because `BLANK_CYCLES` ≥ 1.
- Slot period: `CLK_DIV` cycles. Frame period: 6×`CLK_DIV` cycles.
- `frame_tick` spacing: 6×`CLK_DIV` cycles.
- Anode-low duty per digit: (`CLK_DIV`−`BLANK_CYCLES`)/(6×`CLK_DIV`).
- At most one `an_n` bit is low in any cycle. No two digits overlap, including across the slot boundary.

## Configuration
- `SEVEN_SEG_HEX_EN` defined: codes 10..15 decode to A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
- Not defined: codes 10..15 decode to blank, `seg_n`=7'h7F.
- All other behaviour is identical in both builds.

## Test plan
All scenarios use `CLK_DIV`=8 and `BLANK_CYCLES`=2, connected to the real `seven_seg_mux`.

- **Reset sequence:** `rst_n` low 3 cycles, then `en`=1.
  - During reset: `an_n`=3F, `seg_n`=7F, `mux_sel`=0.
  - `an_n`=3E from cycle 2 to cycle 7 after release.
  - `mux_sel`=1 at cycle 8.
- **Full scan:** digits 0..5 = 3,1,4,1,5,9.
  - Each slot shows the correct `seg_n` while its anode is low (slot 5: 0010000).
  - `frame_tick` pulses once every 48 cycles.
  - `an_n` never has two bits low.
- **Blanking / ghosting:** at every `mux_sel` change, check `an_n`=3F for exactly 2 cycles. Check that `seg_n` is never paired with the wrong anode.
- **Hex decode:** `digit_in`=12.
  - Without the macro: `seg_n`=7F.
  - With `SEVEN_SEG_HEX_EN`: `seg_n`=1000110.
- **Enable and decimal point:**
  - `dp_mask`=6'b000100: `dp_n`=0 only in slot 2.
  - Drop `en` mid-slot 3: `an_n`=3F at once and `mux_sel` holds at 3.
  - Raise `en`: slot 3 restarts with a 2-cycle blank.
- **Async reset mid-frame:** assert `rst_n` low during slot 4 between clock edges. All outputs reach reset values before the next edge.
